unified_mem_arbiter: RTL
========================

Name: unified_mem_arbiter

Overview:
- Shares one single-port SRAM_wrapper instance between the pipeline's instruction fetch (IF) and data memory (MEM) stages, replacing the separate IM and DM macros.
- Each cycle, arbitrates between the two requesters and drives one SRAM command.
- Tags the outstanding read so the response returned one cycle later goes to the correct requester.
- Produces stall signals for the hazard controller.
- MEM has priority by default; a starvation counter guarantees IF forward progress.

Parameters:
ADDR_W, 14, SRAM word-address width (byte address bits [15:2])
DATA_W, 32, data width
STARVE_MAX, 4, consecutive IF losses after which IF wins the next contested cycle (1..15)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
if_req  in  1  IF read request; held stable until if_gnt
if_addr  in  ADDR_W  IF word address
if_flush  in  1  branch/jump flush; kills IF traffic (see Behaviour)
if_gnt  out  1  IF command issued this cycle
if_rvalid  out  1  IF read data valid this cycle
if_rdata  out  DATA_W  IF read data
if_stall  out  1  if_req & ~if_gnt
dm_req  in  1  MEM request; held stable until dm_gnt
dm_web  in  4  byte write enables, low active; 4'hF = read
dm_addr  in  ADDR_W  MEM word address
dm_wdata  in  DATA_W  MEM write data
dm_gnt  out  1  MEM command issued this cycle
dm_rvalid  out  1  MEM read data valid this cycle
dm_rdata  out  DATA_W  MEM read data
dm_stall  out  1  dm_req & ~dm_gnt
sram_cs  out  1  SRAM chip select
sram_oe  out  1  SRAM output enable
sram_web  out  4  SRAM byte write enables, low active
sram_a  out  ADDR_W  SRAM address
sram_di  out  DATA_W  SRAM write data
sram_do  in  DATA_W  SRAM read data, valid the cycle after the read command

Behaviour:
- Reset (rst=0, async):
  - resp_tag=TAG_NONE, starve_cnt=0.
  - All gnt/rvalid/stall outputs 0; rdata 0.
  - sram_cs=0, sram_oe=0, sram_web=4'hF, sram_a=0, sram_di=0.
  - An outstanding read at reset is dropped; no rvalid after release.
- Arbitration (combinational, same cycle):
  - if_ok = if_req & ~if_flush.
  - If only one of dm_req / if_ok is set, that requester wins.
  - If both are set: IF wins iff starve_cnt == STARVE_MAX; otherwise MEM wins.
  - Exactly one gnt at most per cycle.
- Command drive:
  - The winner's address, web and wdata go to sram_a, sram_web, sram_di; sram_cs=1.
  - sram_oe=1 only for a read (IF grant, or MEM grant with dm_web==4'hF).
  - With no winner, outputs take their idle/reset values.
  - The unused sram_di is 0 for IF grants.
- resp_tag register (states TAG_NONE / TAG_IF / TAG_DM):
  - Next value is TAG_IF on an IF grant.
  - TAG_DM on a MEM read grant.
  - TAG_NONE otherwise, including MEM writes and idle cycles.
  - Back-to-back reads: a new command is accepted every cycle, so 1 command/cycle throughput.
- Response:
  - if_rvalid = (resp_tag==TAG_IF) & ~if_flush.
  - dm_rvalid = (resp_tag==TAG_DM).
  - Each rdata = sram_do when its rvalid is set, else 0.
  - Read latency is exactly 1 cycle after gnt.
- Writes: complete on dm_gnt; no rvalid is generated.
- Starvation counter starve_cnt (4 bits):
  - +1 (saturating at STARVE_MAX) when if_ok & dm_gnt.
  - Cleared on if_gnt or when if_ok=0.
- Flush:
  - if_flush in cycle t blocks any IF grant in t.
  - It suppresses an IF response returning in t.
  - MEM traffic is unaffected.
- Simultaneous events:
  - A MEM grant with an IF response returning in the same cycle is legal; the two use disjoint paths.
  - A flush in the same cycle as a returning DM response does not affect dm_rvalid.

Decomposition:
- Package mem_arb_pkg holds:
  - the typedef enum resp_tag_e {TAG_NONE, TAG_IF, TAG_DM};
  - constants MEM_ADDR_W=14, MEM_DATA_W=32, WEB_READ=4'hF.
- One sub-module is natural: mem_arb_prio, holding the starvation counter plus the winner-select logic. Its outputs are if_win/dm_win.
- The top level holds the command mux, resp_tag and response routing.

Test Plan:
- Reset mid-read: IF grant at addr 0x10, assert rst=0 next cycle -> if_rvalid stays 0; all SRAM outputs at idle values; resp_tag=TAG_NONE after release.
- IF-only stream: if_req=1 with addr 0,1,2,3 on consecutive cycles, SRAM preloaded mem[i]=0xA000_000i -> if_gnt=1 every cycle; if_rvalid=1 from cycle 2 with if_rdata 0xA0000000..0xA0000003 in order.
- Contention: if_req and dm_req (read 0x20) together -> dm_gnt=1, if_stall=1; next cycle dm_rvalid=1 with dm_rdata=mem[0x20]; IF granted the following cycle.
- Starvation: if_req held, dm_req continuous with STARVE_MAX=4 -> 4 MEM grants, then if_gnt on the 5th contested cycle, then starve_cnt=0.
- Byte write: dm_web=4'b1100, addr 0x30, wdata 0xDEADBEEF over old 0x11223344 -> sram_web=4'b1100, no dm_rvalid; a later read of 0x30 returns 0x1122BEEF.
- Flush: IF grant at t, if_flush=1 at t+1 with if_req=1 -> if_rvalid=0 and if_gnt=0 at t+1; if_gnt=1 at t+2 once if_flush=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the unified memory arbiter
package mem_arb_pkg;

  localparam int          MEM_ADDR_W = 14;
  localparam int          MEM_DATA_W = 32;
  localparam logic [3:0]  WEB_READ   = 4'hF;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_IF   = 2'd1,
    TAG_DM   = 2'd2
  } resp_tag_e;

  function automatic logic is_read(input logic [3:0] web);
    return web == WEB_READ;
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - MEM-priority winner select with IF starvation counter
module mem_arb_prio #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_ok_i,
  input  logic dm_req_i,
  output logic if_win_o,
  output logic dm_win_o
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_q, starve_d;
  logic       contested;

  assign contested = if_ok_i & dm_req_i;

  always_comb begin
    if_win_o = contested ? (starve_q == STARVE_LIM) : if_ok_i;
    dm_win_o = dm_req_i & ~if_win_o;
  end

  // Counts consecutive contested losses; any cycle IF is not asking resets it.
  always_comb begin
    starve_d = starve_q;
    if (!if_ok_i || if_win_o) begin
      starve_d = 4'd0;
    end else if (dm_win_o && starve_q != STARVE_LIM) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - shares one single-port SRAM between IF and MEM stages
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic [3:0]        dm_web,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  output logic              sram_cs,
  output logic              sram_oe,
  output logic [3:0]        sram_web,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_di,
  input  logic [DATA_W-1:0] sram_do
);

  logic      if_ok, dm_ok;
  logic      if_win, dm_win;
  resp_tag_e tag_q, tag_d;

  // Requests are masked while reset is held so the SRAM sees idle commands.
  assign if_ok = rst & if_req & ~if_flush;
  assign dm_ok = rst & dm_req;

  mem_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk      (clk),
    .rst      (rst),
    .if_ok_i  (if_ok),
    .dm_req_i (dm_ok),
    .if_win_o (if_win),
    .dm_win_o (dm_win)
  );

  always_comb begin
    sram_cs  = 1'b0;
    sram_oe  = 1'b0;
    sram_web = WEB_READ;
    sram_a   = '0;
    sram_di  = '0;
    if (if_win) begin
      sram_cs = 1'b1;
      sram_oe = 1'b1;
      sram_a  = if_addr;
    end else if (dm_win) begin
      sram_cs  = 1'b1;
      sram_oe  = is_read(dm_web);
      sram_web = dm_web;
      sram_a   = dm_addr;
      sram_di  = dm_wdata;
    end
  end

  always_comb begin
    if_gnt   = if_win;
    dm_gnt   = dm_win;
    if_stall = rst & if_req & ~if_win;
    dm_stall = rst & dm_req & ~dm_win;
  end

  // Writes leave no response behind, so only reads set a tag.
  always_comb begin
    tag_d = TAG_NONE;
    if (if_win) begin
      tag_d = TAG_IF;
    end else if (dm_win && is_read(dm_web)) begin
      tag_d = TAG_DM;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q <= TAG_NONE;
    end else begin
      tag_q <= tag_d;
    end
  end

  always_comb begin
    if_rvalid = (tag_q == TAG_IF) & ~if_flush;
    dm_rvalid = (tag_q == TAG_DM);
    if_rdata  = if_rvalid ? sram_do : '0;
    dm_rdata  = dm_rvalid ? sram_do : '0;
  end

endmodule
